// File: rtl/seq101_pkg.sv
// Shared encodings and helpers for the frame-scheduled "101" detector.
package seq101_pkg;

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } det_state_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SHIFT  = 2'b01,
      REPORT = 2'b10
   } ctrl_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq101_core.sv
// Overlapping "101" Moore detector; steps on enable, synchronous clear has priority.
module seq101_core
   import seq101_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       clear,
   input  logic       bit_in,
   output logic [1:0] state,
   output logic       z,
   output logic       match_next
);

   det_state_t cur;
   det_state_t nxt;

   always_comb begin
      nxt = cur;
      case (cur)
         S0: nxt = bit_in ? S1 : S0;
         S1: nxt = bit_in ? S1 : S2;
         S2: nxt = bit_in ? S3 : S0;
         S3: nxt = bit_in ? S1 : S2;
         default: nxt = S0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= S0;
      end else if (clear) begin
         cur <= S0;
      end else if (step) begin
         cur <= nxt;
      end
   end

   assign state      = cur;
   assign z          = (cur == S3);
   assign match_next = (nxt == S3);

endmodule

// File: rtl/seq101_frame_scheduler.sv
// Accepts a frame, shifts it MSB-first through the detector, reports the per-frame match count.
module seq101_frame_scheduler
   import seq101_pkg::*;
#(
   parameter  int DATA_W          = 8,
   parameter  bit CLEAR_PER_FRAME = 1'b1,
   localparam int CNT_W           = clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_hit,
   output logic              busy,
   output logic              det_bit,
   output logic [1:0]        det_state
);

   ctrl_state_t       ctrl;
   logic [DATA_W-1:0] shreg;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  match_cnt;
   logic [CNT_W-1:0]  count_q;
   logic              valid_q;
   logic              accept;
   logic              step;
   logic              clear;
   logic              match_next;
   logic              det_z;

   assign in_ready  = (ctrl == IDLE);
   assign busy      = (ctrl != IDLE);
   assign accept    = ena & in_valid & in_ready;
   assign step      = ena & (ctrl == SHIFT);
   assign clear     = accept & CLEAR_PER_FRAME;
   assign det_bit   = (ctrl == SHIFT) & shreg[DATA_W-1];
   assign out_valid = valid_q;
   assign out_count = count_q;
   assign out_hit   = (count_q != '0);

   seq101_core u_core (
      .clk        (clk),
      .rst        (rst),
      .step       (step),
      .clear      (clear),
      .bit_in     (det_bit),
      .state      (det_state),
      .z          (det_z),
      .match_next (match_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl      <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         match_cnt <= '0;
         count_q   <= '0;
         valid_q   <= 1'b0;
      end else if (ena) begin
         case (ctrl)
            IDLE: begin
               if (in_valid) begin
                  shreg     <= in_data;
                  bit_cnt   <= '0;
                  match_cnt <= '0;
                  ctrl      <= SHIFT;
               end
            end
            SHIFT: begin
               shreg     <= {shreg[DATA_W-2:0], 1'b0};
               bit_cnt   <= bit_cnt + 1'b1;
               match_cnt <= match_cnt + CNT_W'(match_next);
               // The last bit's match must land in the reported count.
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  count_q <= match_cnt + CNT_W'(match_next);
                  valid_q <= 1'b1;
                  ctrl    <= REPORT;
               end
            end
            REPORT: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  ctrl    <= IDLE;
               end
            end
            default: ctrl <= IDLE;
         endcase
      end
   end

   // A counted match must leave the detector sitting in S3.
   assert property (@(posedge clk) disable iff (rst) (step && match_next) |=> det_z);

endmodule

// File: tb/tb_seq101_frame_scheduler.sv
// Randomised frame stimulus against a sliding-window "101" model, two clear-policy instances.
module tb_seq101_frame_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       in_ready, out_valid, out_hit, busy, det_bit;
   logic [3:0] out_count;
   logic [1:0] det_state;
   logic       in_ready_n, out_valid_n, out_hit_n, busy_n, det_bit_n;
   logic [3:0] out_count_n;
   logic [1:0] det_state_n;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // index 0: detector cleared per frame, index 1: history carries across frames
   logic [2:0] win [2];
   int         len [2];
   int         cnt [2];

   always #5 clk = ~clk;

   seq101_frame_scheduler #(.DATA_W(8), .CLEAR_PER_FRAME(1'b1)) dut (
      .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_count(out_count), .out_hit(out_hit), .busy(busy), .det_bit(det_bit),
      .det_state(det_state)
   );

   seq101_frame_scheduler #(.DATA_W(8), .CLEAR_PER_FRAME(1'b0)) dut_nc (
      .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready_n),
      .in_data(in_data), .out_valid(out_valid_n), .out_ready(out_ready),
      .out_count(out_count_n), .out_hit(out_hit_n), .busy(busy_n), .det_bit(det_bit_n),
      .det_state(det_state_n)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic pick(input int mode);
      if (mode == 1) return 1'($urandom_range(0, 1));
      if (mode == 2) return 1'(cyc % 2);
      return 1'b1;
   endfunction

   // Detector state as a function of the bits seen since the last clear.
   function automatic logic [1:0] model_state(input logic [2:0] w, input int l);
      if (l >= 3 && w == 3'b101) return 2'd3;
      if (l >= 1 && w[0])        return 2'd1;
      if (l >= 2 && w[1:0] == 2'b10) return 2'd2;
      return 2'd0;
   endfunction

   task automatic model_clear(input int k);
      win[k] = 3'b000;
      len[k] = 0;
   endtask

   task automatic model_bit(input logic b);
      for (int k = 0; k < 2; k++) begin
         win[k] = {win[k][1:0], b};
         if (len[k] < 3) len[k]++;
         if (len[k] >= 3 && win[k] == 3'b101) cnt[k]++;
      end
   endtask

   task automatic check_states(input string tag);
      chk({tag, "_det_state"},    det_state,   model_state(win[0], len[0]));
      chk({tag, "_det_state_nc"}, det_state_n, model_state(win[1], len[1]));
   endtask

   task automatic run_frame(input logic [7:0] d, input int stall, input int hold);
      logic e;
      logic accepted;
      int   guard;
      int   n;
      in_data   = d;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      accepted  = 1'b0;
      guard     = 0;
      while (!accepted && guard < 50) begin
         e        = pick(stall);
         ena      = e;
         accepted = e & in_ready;
         tick();
         guard++;
      end
      if (!accepted) chk("accept_timeout", 0, 1);
      model_clear(0);
      cnt[0] = 0;
      cnt[1] = 0;
      in_data   = 8'($urandom);
      out_ready = (hold == 0);
      n     = 0;
      guard = 0;
      while (n < 8 && guard < 200) begin
         chk("in_ready_shift", in_ready, 0);
         chk("out_valid_early", out_valid, 0);
         chk("det_bit", det_bit, d[7-n]);
         check_states("shift");
         e   = pick(stall);
         ena = e;
         tick();
         if (e) begin
            model_bit(d[7-n]);
            n++;
         end
         guard++;
      end
      if (n < 8) chk("shift_timeout", n, 8);
      chk("out_valid", out_valid, 1);
      chk("out_valid_nc", out_valid_n, 1);
      chk("out_count", out_count, cnt[0]);
      chk("out_hit", out_hit, cnt[0] != 0);
      chk("out_count_nc", out_count_n, cnt[1]);
      chk("busy_report", busy, 1);
      check_states("report");
      for (int i = 0; i < hold; i++) begin
         ena = pick(stall);
         tick();
         chk("hold_out_valid", out_valid, 1);
         chk("hold_out_count", out_count, cnt[0]);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      accepted  = 1'b0;
      guard     = 0;
      while (!accepted && guard < 50) begin
         e        = pick(stall);
         ena      = e;
         accepted = e;
         tick();
         guard++;
      end
      if (!accepted) chk("drain_timeout", 0, 1);
      chk("out_valid_taken", out_valid, 0);
      chk("in_ready_idle", in_ready, 1);
      chk("busy_idle", busy, 0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic reset_mid_frame();
      in_data  = 8'b1011_0111;
      in_valid = 1'b1;
      ena      = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("mid_busy", busy, 1);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      for (int k = 0; k < 2; k++) model_clear(k);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_count", out_count, 0);
      check_states("rst");
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      run_frame(8'b0000_0101, 0, 1);
   endtask

   initial begin
      rst       = 1'b1;
      ena       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         model_clear(k);
         cnt[k] = 0;
      end
      #20;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_det_bit", det_bit, 0);
      chk("reset_out_hit", out_hit, 0);
      chk("reset_out_count", out_count, 0);
      check_states("reset");
      rst = 1'b0;
      tick();

      run_frame(8'b1010_1010, 0, 0);
      run_frame(8'h00, 0, 1);
      run_frame(8'hFF, 0, 1);
      run_frame(8'b0000_0010, 0, 0);
      run_frame(8'b1000_0000, 0, 0);
      run_frame(8'h5A, 0, 5);
      run_frame(8'b1011_0101, 2, 2);
      reset_mid_frame();
      repeat (40) run_frame(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
